// File: rtl/ones_pattern_generator_pkg.sv
// Shared types and helpers for the ones pattern generator.
// Optional self-check: ONES_PATTERN_GENERATOR_SELFCHECK_EN.
package ones_pattern_generator_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ones_pattern_generator_combination_step.sv
// Next combination with the same popcount, in ascending order.
// Lowest set bit found with a priority encoder; no divider.
module combination_step #(
  parameter int INPUT_FEATURES = 4
) (
  input  logic [INPUT_FEATURES-1:0] x,
  output logic [INPUT_FEATURES-1:0] next
);

  localparam int TW = (INPUT_FEATURES > 1) ? $clog2(INPUT_FEATURES) : 1;

  logic [INPUT_FEATURES-1:0] c;
  logic [INPUT_FEATURES-1:0] r;
  logic [TW-1:0]             tz;

  assign c = x & (~x + 1'b1);
  assign r = x + c;

  always_comb begin
    tz = '0;
    for (int i = INPUT_FEATURES - 1; i >= 0; i--) begin
      if (c[i]) tz = TW'(i);
    end
  end

  assign next = r | (((r ^ x) >> 2) >> tz);

endmodule

// File: rtl/ones_pattern_generator.sv
// Emits every INPUT_FEATURES-bit vector with K ones, ascending.
// Optional popcount self-check: ONES_PATTERN_GENERATOR_SELFCHECK_EN.
module ones_pattern_generator
  import ones_pattern_generator_pkg::*;
#(
  parameter int INPUT_FEATURES = 4,
  localparam int CW = count_width(INPUT_FEATURES)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [CW-1:0]             ones_i,
  output logic                      busy_o,
  output logic [INPUT_FEATURES-1:0] features_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic                      error_o,
  output logic                      mismatch_o
);

  localparam logic [INPUT_FEATURES-1:0] ALL = '1;

  state_t                    state, state_n;
  logic [CW-1:0]             k, k_n;
  logic [INPUT_FEATURES-1:0] feat, feat_n;
  logic [INPUT_FEATURES-1:0] step;
  logic [INPUT_FEATURES-1:0] last_mask;
  logic                      err, err_n;
  logic                      fire;

  combination_step #(
    .INPUT_FEATURES(INPUT_FEATURES)
  ) u_step (
    .x    (feat),
    .next (step)
  );

  // Final vector has the K ones packed at the top.
  assign last_mask  = ~(ALL >> k);
  assign valid_o    = (state == RUN);
  assign busy_o     = (state == RUN);
  assign last_o     = valid_o && (feat == last_mask);
  assign features_o = feat;
  assign error_o    = err;
  assign fire       = valid_o && ready_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      k     <= '0;
      feat  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      feat  <= feat_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    feat_n  = feat;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (ones_i > CW'(INPUT_FEATURES)) begin
            err_n = 1'b1;
          end else begin
            k_n     = ones_i;
            feat_n  = ~(ALL << ones_i);
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          if (last_o) begin
            state_n = IDLE;
            feat_n  = '0;
          end else begin
            feat_n = step;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ONES_PATTERN_GENERATOR_SELFCHECK_EN
  logic mis;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      mis <= 1'b0;
    end else if (fire && (popcount(64'(feat)) != int'(k))) begin
      mis <= 1'b1;
    end
  end

  assign mismatch_o = mis;
`else
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_ones_pattern_generator.sv
// Bench for ones_pattern_generator: directed steps plus random sweeps
// against a reference list built by enumerating all vectors.
module tb_ones_pattern_generator;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] ones_i = '0;
  logic          ready_i = 1'b0;
  logic          busy_o;
  logic [N-1:0]  features_o;
  logic          valid_o;
  logic          last_o;
  logic          error_o;
  logic          mismatch_o;

  int checks = 0;
  int errors = 0;
  int total_hs = 0;

  always #5 clk = ~clk;

  ones_pattern_generator #(
    .INPUT_FEATURES(N)
  ) dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .ones_i     (ones_i),
    .busy_o     (busy_o),
    .features_o (features_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .error_o    (error_o),
    .mismatch_o (mismatch_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // mode 0: ready always high; 1: pattern 1,0,0; 2: random
  task automatic run_seq(input int k, input int mode);
    logic [N-1:0] exp_q[$];
    int hs, p, cyc;
    logic r;
    for (int v = 0; v < (1 << N); v++)
      if ($countones(v) == k) exp_q.push_back(N'(v));
    @(negedge clk);
    start_i = 1'b1;
    ones_i  = CW'(k);
    @(negedge clk);
    start_i = 1'b0;
    if (k > N) begin
      chk("err_pulse", 32'(error_o), 1);
      chk("err_valid", 32'(valid_o), 0);
      chk("err_busy", 32'(busy_o), 0);
      @(negedge clk);
      chk("err_clear", 32'(error_o), 0);
      chk("err_valid2", 32'(valid_o), 0);
      chk("err_busy2", 32'(busy_o), 0);
      return;
    end
    chk("busy_run", 32'(busy_o), 1);
    hs = 0;
    p = 0;
    cyc = 0;
    while (hs < exp_q.size() && cyc < 64) begin
      chk("valid", 32'(valid_o), 1);
      chk("features", 32'(features_o), 32'(exp_q[hs]));
      chk("last", 32'(last_o), 32'(hs == exp_q.size() - 1));
      chk("mismatch", 32'(mismatch_o), 0);
      case (mode)
        0:       r = 1'b1;
        1:       r = (p % 3 == 0);
        default: r = 1'($urandom_range(1, 0));
      endcase
      ready_i = r;
      p++;
      @(negedge clk);
      cyc++;
      if (r) begin
        hs++;
        total_hs++;
      end
    end
    ready_i = 1'b0;
    if (cyc >= 64) chk("timeout", 0, 1);
    chk("hs_count", 32'(hs), 32'(binom(N, k)));
    chk("done_valid", 32'(valid_o), 0);
    chk("done_busy", 32'(busy_o), 0);
    chk("done_last", 32'(last_o), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_last", 32'(last_o), 0);
    chk("rst_error", 32'(error_o), 0);
    chk("rst_mismatch", 32'(mismatch_o), 0);
    chk("rst_features", 32'(features_o), 0);
    reset_i = 1'b0;

    run_seq(2, 0);
    run_seq(0, 0);
    run_seq(4, 0);
    run_seq(5, 0);
    run_seq(1, 1);

    // Async reset mid-sequence, after two K=3 vectors
    @(negedge clk);
    start_i = 1'b1;
    ones_i  = CW'(3);
    @(negedge clk);
    start_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("k3_third", 32'(features_o), 32'h0d);
    ready_i = 1'b0;
    #1 reset_i = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_valid", 32'(valid_o), 0);
    chk("arst_features", 32'(features_o), 0);
    chk("arst_last", 32'(last_o), 0);
    chk("arst_error", 32'(error_o), 0);
    reset_i = 1'b0;
    run_seq(1, 0);

    // Full sweep counts handshakes
    total_hs = 0;
    for (int k = 0; k <= N; k++) run_seq(k, 2);
    chk("sweep_hs", 32'(total_hs), 16);
    chk("sweep_mismatch", 32'(mismatch_o), 0);

    for (int i = 0; i < 12; i++) run_seq($urandom_range(7, 0), 2);
    chk("final_mismatch", 32'(mismatch_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
